// File: rtl/sample_serializer_pkg.sv
// -----------------------------------------------------------------------------
// sample_serializer_pkg
//   Constants and helpers that are shared with the tone generator and used by
//   the I2S sample serializer.
//   - SAMPLE_W         : width of one mixed audio sample (also the I2S slot length)
//   - FRAME_BITS       : bclk periods in one stereo frame (two 16-bit slots)
//   - BCLK_DIV_DEFAULT : clk cycles per bclk half-period, chosen so that one
//                        frame spans exactly one 10-bit master-count period
//   - lrck_for_bit     : word-select level for a given frame bit position
//   - slot_index       : which sample bit goes out at a given frame bit position
// -----------------------------------------------------------------------------
package sample_serializer_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int FRAME_BITS       = 32;
  localparam int MASTER_CNT_W     = 10;
  // Each frame bit takes two bclk half-periods.
  localparam int BCLK_DIV_DEFAULT = (1 << MASTER_CNT_W) / (2 * FRAME_BITS);

  localparam int BIT_CNT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [BIT_CNT_W-1:0]       bit_idx_t;

  // Word select runs one bclk ahead of the data: it goes high on the LSB of
  // the left slot (bit 15) and drops on the LSB of the right slot (bit 31).
  function automatic logic lrck_for_bit(bit_idx_t b);
    return (b >= bit_idx_t'(15)) && (b <= bit_idx_t'(30));
  endfunction

  // Both slots carry the same sample MSB first, so the bit within the sample
  // is 15 minus the position inside the current 16-bit slot.
  function automatic logic [3:0] slot_index(bit_idx_t b);
    return 4'd15 - b[3:0];
  endfunction

endpackage

// File: rtl/sample_serializer_if.sv
// -----------------------------------------------------------------------------
// sample_serializer_if
//   Sample bus from the tone generator to the serializer.
//   - data_in       : mixed signed sample, two's complement
//   - data_valid_in : one-cycle strobe; the consumer captures data_in
//   Modports: master = tone generator (drives), slave = serializer (consumes).
// -----------------------------------------------------------------------------
interface sample_serializer_if;
  import sample_serializer_pkg::*;

  sample_t data_in;
  logic    data_valid_in;

  modport master (output data_in, output data_valid_in);
  modport slave  (input  data_in, input  data_valid_in);

endinterface

// File: rtl/sample_serializer_bclk_prescaler.sv
// -----------------------------------------------------------------------------
// bclk_prescaler
//   Divides clk_in down to the I2S bit clock.
//   - clk_in       : system clock
//   - reset_n_in   : synchronous, active-low reset (counter 0, bclk low)
//   - bclk_out     : bit clock, toggles every BCLK_DIV clk_in cycles
//   - fall_evt_out : high in the cycle whose rising clk_in edge takes bclk
//                    from 1 to 0, so serial state can change on that same edge
// -----------------------------------------------------------------------------
module bclk_prescaler #(
  parameter int BCLK_DIV = 16
) (
  input  logic clk_in,
  input  logic reset_n_in,
  output logic bclk_out,
  output logic fall_evt_out
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             term;

  always_comb begin
    term         = (cnt_q == CNT_MAX);
    cnt_d        = term ? '0 : cnt_q + 1'b1;
    bclk_d       = term ? ~bclk_q : bclk_q;
    // Decoded from current state so the parent updates on the falling edge
    // itself rather than one cycle late.
    fall_evt_out = term & bclk_q;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_out = bclk_q;

endmodule

// File: rtl/sample_serializer.sv
// -----------------------------------------------------------------------------
// sample_serializer
//   Consumer end of the tone generator's sample output. Buffers each mixed
//   sample in a holding register and sends it as an I2S stereo frame (same
//   mono sample in left and right slots) to an external DAC.
//   - clk_in        : system clock
//   - reset_n_in    : synchronous, active-low reset
//   - sif (slave)   : data_in / data_valid_in sample bus
//   - bclk_out      : serial bit clock (period 2*BCLK_DIV clk_in cycles)
//   - lrck_out      : word select, 0 = left, 1 = right
//   - sdata_out     : serial data, MSB first, changes on falling bclk
//   - underrun_out  : one-cycle pulse, frame started with a stale sample
//   - overrun_out   : one-cycle pulse, unconsumed sample was overwritten
// -----------------------------------------------------------------------------
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEFAULT,
  parameter int SAMPLE_W = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  sample_serializer_if.slave        sif,
  output logic                      bclk_out,
  output logic                      lrck_out,
  output logic                      sdata_out,
  output logic                      underrun_out,
  output logic                      overrun_out
);

  logic fall_evt;

  bclk_prescaler #(
    .BCLK_DIV (BCLK_DIV)
  ) u_prescaler (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .bclk_out     (bclk_out),
    .fall_evt_out (fall_evt)
  );

  bit_idx_t                   bit_cnt_q, bit_cnt_d;
  logic signed [SAMPLE_W-1:0] holding_q, holding_d;
  logic signed [SAMPLE_W-1:0] frame_q,   frame_d;
  logic                       fresh_q,   fresh_d;
  logic                       lrck_q,    lrck_d;
  logic                       sdata_q,   sdata_d;
  logic                       underrun_q, underrun_d;
  logic                       overrun_q,  overrun_d;
  logic                       load;
  logic                       capture;

  always_comb begin
    capture   = sif.data_valid_in;
    // A new frame starts on the fall event that wraps the bit counter to 0.
    load      = fall_evt && (bit_cnt_q == LAST_BIT);

    bit_cnt_d = fall_evt ? bit_cnt_q + 1'b1 : bit_cnt_q;

    // The frame takes the holding value from before any same-cycle write,
    // so a sample arriving on the load cycle waits for the next frame.
    frame_d   = load    ? holding_q   : frame_q;
    holding_d = capture ? sif.data_in : holding_q;

    // A same-cycle capture keeps the new sample marked as unconsumed.
    if (capture)   fresh_d = 1'b1;
    else if (load) fresh_d = 1'b0;
    else           fresh_d = fresh_q;

    // Serial outputs are derived from the post-increment bit position and the
    // post-load frame, so the MSB appears on the very fall event that loads.
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    if (fall_evt) begin
      lrck_d  = lrck_for_bit(bit_cnt_d);
      sdata_d = frame_d[slot_index(bit_cnt_d)];
    end

    underrun_d = load & ~fresh_q;
    overrun_d  = capture & fresh_q & ~load;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      bit_cnt_q  <= LAST_BIT;
      holding_q  <= '0;
      frame_q    <= '0;
      fresh_q    <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      holding_q  <= holding_d;
      frame_q    <= frame_d;
      fresh_q    <= fresh_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign lrck_out     = lrck_q;
  assign sdata_out    = sdata_q;
  assign underrun_out = underrun_q;
  assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_sample_serializer.sv
// -----------------------------------------------------------------------------
// tb_sample_serializer
//   Self-checking bench for sample_serializer with BCLK_DIV = 16. A reference
//   model derives every expected output from the cycle count since reset and
//   a queue of samples written since the last frame start.
// -----------------------------------------------------------------------------
module tb_sample_serializer;
  import sample_serializer_pkg::*;

  localparam int BCLK_DIV   = 16;
  localparam int FRAME_CYC  = 64 * BCLK_DIV;
  localparam int BIT_CYC    = 2 * BCLK_DIV;
  localparam int FIRST_FALL = 2 * BCLK_DIV;

  logic clk_in = 1'b0;
  logic reset_n_in;
  logic bclk_out, lrck_out, sdata_out, underrun_out, overrun_out;

  sample_serializer_if sif();

  sample_serializer #(
    .BCLK_DIV (BCLK_DIV)
  ) dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .sif          (sif),
    .bclk_out     (bclk_out),
    .lrck_out     (lrck_out),
    .sdata_out    (sdata_out),
    .underrun_out (underrun_out),
    .overrun_out  (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n;            // rising edges since the reset edge
  logic [15:0] pending[$];   // samples written since the last frame start
  logic [15:0] cur_word;     // sample carried by the current frame

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h, expected %h", tag, n, obs, exp);
    end
  endtask

  function automatic bit is_load_edge(int e);
    return (e >= FIRST_FALL) && (((e - FIRST_FALL) % FRAME_CYC) == 0);
  endfunction

  function automatic int next_load();
    if (n < FIRST_FALL) return FIRST_FALL;
    return FIRST_FALL + ((n - FIRST_FALL) / FRAME_CYC + 1) * FRAME_CYC;
  endfunction

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic step(input bit rst_n, input bit v, input logic [15:0] d);
    bit   exp_under, exp_over, exp_bclk, exp_lrck, exp_sdata;
    int   b, pos;
    reset_n_in        = rst_n;
    sif.data_valid_in = v;
    sif.data_in       = d;
    @(posedge clk_in);
    #1;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    if (!rst_n) begin
      n        = 0;
      cur_word = '0;
      pending.delete();
    end else begin
      n++;
      if (is_load_edge(n)) begin
        // With nothing new, the previously sent sample goes out again.
        exp_under = (pending.size() == 0);
        if (pending.size() > 0) cur_word = pending[$];
        pending.delete();
      end
      if (v) begin
        exp_over = !is_load_edge(n) && (pending.size() > 0);
        pending.push_back(d);
      end
    end

    exp_bclk  = rst_n && (((n / BCLK_DIV) % 2) == 1);
    exp_lrck  = 1'b0;
    exp_sdata = 1'b0;
    if (rst_n && n >= FIRST_FALL) begin
      b         = ((n - FIRST_FALL) / BIT_CYC) % 32;
      exp_lrck  = (b >= 15) && (b <= 30);
      pos       = (b < 16) ? 15 - b : 31 - b;
      exp_sdata = cur_word[pos];
    end

    chk("bclk",     32'(bclk_out),     32'(exp_bclk));
    chk("lrck",     32'(lrck_out),     32'(exp_lrck));
    chk("sdata",    32'(sdata_out),    32'(exp_sdata));
    chk("underrun", 32'(underrun_out), 32'(exp_under));
    chk("overrun",  32'(overrun_out),  32'(exp_over));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 16'h0);
  endtask

  task automatic idle_to(input int t);
    while (n < t) step(1'b1, 1'b0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b1, 1'b1, d);
  endtask

  task automatic rst_pulse();
    step(1'b0, 1'b0, 16'h0);
  endtask

  int L;

  initial begin
    n                 = 0;
    cur_word          = '0;
    reset_n_in        = 1'b0;
    sif.data_valid_in = 1'b0;
    sif.data_in       = '0;
    rst_pulse();
    rst_pulse();

    // Sample early after reset: first frame carries it, no underrun.
    idle(4);
    wr(16'hA5C3);
    idle_to(FIRST_FALL + FRAME_CYC + 40);

    // No sample: zero frame with underrun, then 8000 in the next frame.
    rst_pulse();
    idle(500);
    wr(16'h8000);
    idle_to(FIRST_FALL + FRAME_CYC + FRAME_CYC / 2);

    // Two writes within one frame: overrun on the second, newest wins.
    wr(16'h1234);
    idle(10);
    wr(16'h7FFF);
    idle_to(next_load() + FRAME_CYC / 2);

    // Write landing exactly on the load edge.
    wr(16'h0F0F);
    L = next_load();
    idle_to(L - 1);
    wr(16'h00FF);
    idle_to(L + FRAME_CYC + FRAME_CYC / 2);

    // One frame without writes: the sample repeats with an underrun.
    wr(16'h4321);
    L = next_load();
    idle_to(L + FRAME_CYC + FRAME_CYC / 2);

    // Reset in the middle of a frame at bit 20.
    L = next_load();
    idle_to(L + 20 * BIT_CYC);
    rst_pulse();
    idle_to(FIRST_FALL + FRAME_CYC + 100);

    // A multi-cycle strobe counts as back-to-back writes.
    wr(16'h1111);
    wr(16'h2222);
    wr(16'h3333);
    idle_to(next_load() + 50);

    // Random traffic, including writes that coincide with frame starts.
    for (int f = 0; f < 8; f++) begin
      L = next_load() + FRAME_CYC;
      while (n < L) begin
        bit v;
        if (is_load_edge(n + 1)) v = ($urandom_range(0, 2) == 0);
        else                     v = ($urandom_range(0, 299) == 0);
        step(1'b1, v, 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
